// File: rtl/fc_pkg.sv
// Shared types, constants and the output ReLU/saturation helper for the fully-connected layer.
package fc_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned SatW = 64;

  typedef logic [2:0] fc_state_t;

  localparam fc_state_t StIdle  = 3'd0;
  localparam fc_state_t StBias  = 3'd1;
  localparam fc_state_t StMac   = 3'd2;
  localparam fc_state_t StDrain = 3'd3;
  localparam fc_state_t StWrite = 3'd4;
  localparam fc_state_t StDone  = 3'd5;

  // Negative sums clamp to 0, anything above the 8-bit range clamps to 255.
  function automatic logic [DW-1:0] relu_sat(input logic signed [SatW-1:0] v);
    if (v[SatW-1]) begin
      return '0;
    end else if (v > 64'sd255) begin
      return '1;
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Control, memory-read and result-write signals of the fully-connected layer controller.
interface fc_layer_ctrl_if #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 200
) ();
  import fc_pkg::*;

  localparam int unsigned IAW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned WAW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int unsigned BAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic           start;
  logic           busy;
  logic           done;
  logic           in_re;
  logic [IAW-1:0] in_addr;
  logic [DW-1:0]  in_rdata;
  logic           w_re;
  logic [WAW-1:0] w_addr;
  logic [DW-1:0]  w_rdata;
  logic           b_re;
  logic [BAW-1:0] b_addr;
  logic [DW-1:0]  b_rdata;
  logic           out_valid;
  logic           out_ready;
  logic [BAW-1:0] out_addr;
  logic [DW-1:0]  out_data;

  modport master (
    input  start, in_rdata, w_rdata, b_rdata, out_ready,
    output busy, done, in_re, in_addr, w_re, w_addr, b_re, b_addr,
           out_valid, out_addr, out_data
  );

  modport slave (
    output start, in_rdata, w_rdata, b_rdata, out_ready,
    input  busy, done, in_re, in_addr, w_re, w_addr, b_re, b_addr,
           out_valid, out_addr, out_data
  );

endinterface

// File: rtl/fc_mac.sv
// Signed multiply-accumulate datapath: bias load, product accumulate, clear and saturated result.
module fc_mac
  import fc_pkg::*;
#(
  parameter int unsigned AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 accum,
  input  logic signed [DW-1:0] b_rdata,
  input  logic signed [DW-1:0] in_rdata,
  input  logic signed [DW-1:0] w_rdata,
  output logic        [DW-1:0] result
);

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [2*DW-1:0] prod;

  assign prod = in_rdata * w_rdata;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = {{(AW - DW){b_rdata[DW-1]}}, b_rdata};
    end else if (accum) begin
      acc_d = acc_q + {{(AW - 2 * DW){prod[2*DW-1]}}, prod};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign result = relu_sat({{(SatW - AW){acc_q[AW-1]}}, acc_q});

endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer: per output node reads bias, streams N_IN activation/weight
// pairs through the MAC, then writes the saturated result with a valid/ready handshake.
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 200,
  parameter int unsigned AW    = 24
) (
  input logic             clk,
  input logic             rst,
  fc_layer_ctrl_if.master bus
);

  localparam int unsigned IAW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned WAW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int unsigned BAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  fc_state_t      state_q, state_d;
  logic [BAW-1:0] n_q, n_d;
  logic [IAW-1:0] j_q, j_d;
  // Weight address runs linearly through the layer, equal to n*N_IN+j without a multiplier.
  logic [WAW-1:0] w_ptr_q, w_ptr_d;

  logic mac_clear, mac_load, mac_accum;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    j_d     = j_q;
    w_ptr_d = w_ptr_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          n_d     = '0;
          w_ptr_d = '0;
          state_d = StBias;
        end
      end
      StBias: begin
        j_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        j_d     = j_q + IAW'(1);
        w_ptr_d = w_ptr_q + WAW'(1);
        if (j_q == IAW'(N_IN - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        if (bus.out_ready) begin
          if (n_q == BAW'(N_OUT - 1)) begin
            state_d = StDone;
          end else begin
            n_d     = n_q + BAW'(1);
            state_d = StBias;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      j_q     <= '0;
      w_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      j_q     <= j_d;
      w_ptr_q <= w_ptr_d;
    end
  end

  // Bias arrives during MAC j=0; each product lands one cycle after its read, DRAIN takes the last.
  assign mac_clear = (state_q == StIdle) && bus.start;
  assign mac_load  = (state_q == StMac) && (j_q == '0);
  assign mac_accum = ((state_q == StMac) && (j_q != '0)) || (state_q == StDrain);

  fc_mac #(
    .AW(AW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (mac_clear),
    .load     (mac_load),
    .accum    (mac_accum),
    .b_rdata  (bus.b_rdata),
    .in_rdata (bus.in_rdata),
    .w_rdata  (bus.w_rdata),
    .result   (bus.out_data)
  );

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.b_re      = (state_q == StBias);
  assign bus.in_re     = (state_q == StMac);
  assign bus.w_re      = (state_q == StMac);
  assign bus.out_valid = (state_q == StWrite);
  assign bus.b_addr    = n_q;
  assign bus.in_addr   = j_q;
  assign bus.w_addr    = w_ptr_q;
  assign bus.out_addr  = n_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Self-checking bench for fc_layer_ctrl (N_IN=4, N_OUT=3) with memory models and a reference sum.
module tb_fc_layer_ctrl;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned AW    = 24;
  localparam int          NODE_LAT  = N_IN + 3;
  localparam int          LAYER_LAT = N_OUT * NODE_LAT;

  logic clk;
  logic rst;

  fc_layer_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  fc_layer_ctrl #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .AW   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [7:0] act  [N_IN];
  logic signed [7:0] wt   [N_IN*N_OUT];
  logic signed [7:0] bias [N_OUT];

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_addr_q[$];
  int wr_data_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data valid the cycle after the enable.
  always @(posedge clk) begin
    if (bus.in_re) bus.in_rdata <= act[bus.in_addr];
    if (bus.w_re)  bus.w_rdata  <= wt[bus.w_addr];
    if (bus.b_re)  bus.b_rdata  <= bias[bus.b_addr];
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int ref_node(input int n);
    int s;
    s = int'(bias[n]);
    for (int j = 0; j < N_IN; j++) s += int'(act[j]) * int'(wt[n*N_IN + j]);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic fill_uniform(input int a, input int w, input int b);
    for (int j = 0; j < N_IN; j++) act[j] = 8'(a);
    for (int k = 0; k < N_IN*N_OUT; k++) wt[k] = 8'(w);
    for (int n = 0; n < N_OUT; n++) bias[n] = 8'(b);
  endtask

  task automatic fill_random();
    for (int j = 0; j < N_IN; j++) act[j] = 8'($urandom_range(0, 255));
    for (int k = 0; k < N_IN*N_OUT; k++) wt[k] = 8'($urandom_range(0, 255));
    for (int n = 0; n < N_OUT; n++) bias[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, int'({bus.busy, bus.done, bus.out_valid, bus.in_re, bus.w_re, bus.b_re}), 0);
    check({tag, "_addr"}, int'({bus.in_addr, bus.w_addr, bus.b_addr, bus.out_addr}), 0);
    check({tag, "_data"}, int'(bus.out_data), 0);
  endtask

  // Runs one layer. Stalls out_ready for stall_len cycles on node stall_node's WRITE and
  // pulses start again lat==pulse_at cycles after acceptance. Returns cycles from accept to done.
  task automatic run_layer(input int stall_node, input int stall_len, input int pulse_at,
                           output int lat);
    int stalls;
    int held;
    stalls = 0;
    held   = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 1000) begin
      @(negedge clk);
      bus.start = (lat == pulse_at);
      if (bus.out_valid && int'(bus.out_addr) == stall_node && stalls < stall_len) begin
        if (stalls == 0) held = int'(bus.out_data);
        else check("stall_data_stable", int'(bus.out_data), held);
        check("stall_no_reads", int'({bus.in_re, bus.w_re, bus.b_re}), 0);
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        wr_addr_q.push_back(int'(bus.out_addr));
        wr_data_q.push_back(int'(bus.out_data));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    if (stall_len > 0) check("stall_cycles", stalls, stall_len);
    @(posedge clk);
    #1;
    check("done_one_cycle", int'({bus.done, bus.busy}), 0);
  endtask

  // Compares the captured writes against per-node expectations (exp_all < 0 uses the model).
  task automatic check_writes(input int exp_all);
    int ga, gd, ed;
    check("write_count", wr_addr_q.size(), N_OUT);
    for (int i = 0; i < N_OUT; i++) begin
      ga = (i < wr_addr_q.size()) ? wr_addr_q[i] : -1;
      gd = (i < wr_data_q.size()) ? wr_data_q[i] : -1;
      ed = (exp_all < 0) ? ref_node(i) : exp_all;
      check("write_addr", ga, i);
      check("write_data", gd, ed);
    end
  endtask

  typedef struct {
    int a;
    int w;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[8];
  int   lat;
  int   k;

  initial begin
    vecs[0] = '{a: 1,   w: 2,   b: 3,    exp: 11};
    vecs[1] = '{a: 10,  w: -1,  b: 0,    exp: 0};
    vecs[2] = '{a: 127, w: 127, b: 127,  exp: 255};
    vecs[3] = '{a: -3,  w: 5,   b: 100,  exp: 40};
    vecs[4] = '{a: 5,   w: 6,   b: 127,  exp: 247};
    vecs[5] = '{a: 8,   w: 8,   b: 0,    exp: 255};
    vecs[6] = '{a: 0,   w: 0,   b: -5,   exp: 0};
    vecs[7] = '{a: -128, w: -128, b: -128, exp: 255};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    fill_uniform(0, 0, 0);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      fill_uniform(vecs[v].a, vecs[v].w, vecs[v].b);
      run_layer(-1, 0, -1, lat);
      check("layer_latency", lat, LAYER_LAT);
      check_writes(vecs[v].exp);
    end

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_layer(-1, 0, -1, lat);
      check("rand_latency", lat, LAYER_LAT);
      check_writes(-1);
    end

    // Back-pressure on node 1 for five cycles.
    fill_uniform(1, 2, 3);
    run_layer(1, 5, -1, lat);
    check("stall_latency", lat, LAYER_LAT + 5);
    check_writes(11);

    // Start pulsed mid-layer must be ignored.
    fill_random();
    run_layer(-1, 0, 9, lat);
    check("restart_latency", lat, LAYER_LAT);
    check_writes(-1);
    check("restart_idle_after", int'(bus.busy), 0);

    // Reset during node 1 MAC, then a fresh layer with new data.
    fill_random();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (!(bus.b_re && int'(bus.b_addr) == 1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach_node1_bias", int'(k < 100), 1);
    @(negedge clk);
    @(negedge clk);
    check("mid_mac_reads", int'(bus.in_re), 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    run_layer(-1, 0, -1, lat);
    check("post_rst_latency", lat, LAYER_LAT);
    check_writes(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter N_IN, default 16, inputs (and weights) per output node; SHALL be >= 2.
REQ-002 Parameter N_OUT, default 200, output nodes per layer; SHALL be >= 1.
REQ-003 Parameter AW, default 24, signed accumulator width.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin layer; sampled only in IDLE.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse when the layer is complete.
REQ-009 in_re / in_addr  out  1 / clog2(N_IN)  input-activation memory read.
REQ-010 in_rdata  in  8  signed activation, valid one cycle after in_re.
REQ-011 w_re / w_addr  out  1 / clog2(N_IN*N_OUT)  weight memory read.
REQ-012 w_rdata  in  8  signed weight, valid one cycle after w_re.
REQ-013 b_re / b_addr  out  1 / clog2(N_OUT)  bias memory read.
REQ-014 b_rdata  in  8  signed bias, valid one cycle after b_re.
REQ-015 out_valid / out_ready  out / in  1 / 1  result write handshake.
REQ-016 out_addr / out_data  out  clog2(N_OUT) / 8  node index and unsigned result.

Function
REQ-017 FSM states SHALL be IDLE, BIAS, MAC, DRAIN, WRITE, DONE.
REQ-018 IDLE: start=1 SHALL clear node counter n to 0 and go to BIAS; start=0 stays.
REQ-019 BIAS (1 cycle): b_re=1, b_addr=n; next MAC with j=0.
REQ-020 MAC (N_IN cycles, j=0..N_IN-1): in_re=w_re=1, in_addr=j, w_addr=n*N_IN+j.
REQ-021 First MAC cycle SHALL load acc with sign-extended b_rdata; each later MAC cycle and DRAIN SHALL add the full-precision signed product of the previous cycle's in_rdata*w_rdata.
REQ-022 After j=N_IN-1 go to DRAIN (1 cycle, no reads), then WRITE.
REQ-023 WRITE: out_valid=1, out_addr=n, out_data = 0 if acc<0, 255 if acc>255, else acc[7:0]; values SHALL stay stable until out_ready=1.
REQ-024 WRITE handshake: n=N_OUT-1 -> DONE; else n+1 and BIAS.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 With out_ready held high, per-node latency SHALL be N_IN+3 cycles; done SHALL occur N_OUT*(N_IN+3) cycles after the cycle start is accepted.
REQ-027 start while busy SHALL be ignored.
REQ-028 All read enables SHALL be 0 outside BIAS/MAC; addresses are don't-care when enables are 0.
REQ-029 Accumulation SHALL not wrap for N_IN*16384+128 < 2^(AW-1); no overflow handling beyond that.

Reset
REQ-030 rst SHALL force IDLE, n=0, j=0, acc=0, and busy, done, out_valid, in_re, w_re, b_re, all addresses and out_data to 0, in any state.
REQ-031 After rst release a new start SHALL recompute from node 0; no partial state is retained.

Structure
REQ-032 Package fc_pkg SHALL hold the state enum, the data width constant (8), and the ReLU/saturation function.
REQ-033 Sub-module fc_mac SHALL implement acc load-bias / accumulate / clear and the saturated result; fc_layer_ctrl holds FSM, counters and address generation.

Verification (N_IN=4, N_OUT=3)
REQ-034 All activations 1, weights 2, biases 3, out_ready=1 -> three writes addr 0,1,2 data 11; done exactly 21 cycles after start.
REQ-035 Activations 10, weights -1, bias 0 -> all out_data 0 (ReLU).
REQ-036 Activations 127, weights 127, bias 127 (acc 64643) -> all out_data 255.
REQ-037 out_ready low 5 cycles during node 1 WRITE -> out_valid, out_addr=1, out_data stable; no reads issued; total time +5 cycles.
REQ-038 Pulse start while busy -> ignored, results unchanged; rst mid-MAC of node 1 -> all outputs 0 next cycle, new start rewrites nodes 0..2 correctly.
